alu_main: RTL and testbench

//  Mini comparison/flag ALU: applies one of eight 1-bit-result functions to two

---
 rtl/alu_main.sv | 54 +++++
 tb/tb_alu_main.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_main.sv
// Registered 1-bit comparison/flag ALU: one of eight unsigned functions of a and b,
// selected by fxn, with a single cycle of latency and synchronous reset.
module alu_main #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fxn,
  output logic             finalresult
);

  typedef enum logic [2:0] {
    FN_EQ     = 3'b000,
    FN_NE     = 3'b001,
    FN_GT     = 3'b010,
    FN_GE     = 3'b011,
    FN_LT     = 3'b100,
    FN_LE     = 3'b101,
    FN_CARRY  = 3'b110,
    FN_PARITY = 3'b111
  } fxn_e;

  fxn_e           sel;
  logic [WIDTH:0] sum;
  logic           res;

  assign sel = fxn_e'(fxn);

  // Zero-extend both operands so bit WIDTH of the sum is the carry-out.
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res = 1'b0;
    case (sel)
      FN_EQ:     res = (a == b);
      FN_NE:     res = (a != b);
      FN_GT:     res = (a >  b);
      FN_GE:     res = (a >= b);
      FN_LT:     res = (a <  b);
      FN_LE:     res = (a <= b);
      FN_CARRY:  res = sum[WIDTH];
      FN_PARITY: res = ^(a ^ b);
      default:   res = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) finalresult <= 1'b0;
    else     finalresult <= res;
  end

endmodule

// File: tb/tb_alu_main.sv
// Bench for alu_main: directed boundary cases, mid-run reset, exhaustive sweep and
// randomized reset-interleaved vectors checked against an arithmetic reference.
module tb_alu_main;
  localparam int WIDTH = 6;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a   = '0;
  logic [WIDTH-1:0] b   = '0;
  logic [2:0]       fxn = '0;
  logic             finalresult;

  int n_vec = 0;
  int n_bad = 0;

  alu_main #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .fxn         (fxn),
    .finalresult (finalresult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (a=%0d b=%0d fxn=%0d rst=%b)",
               tag, got, exp, a, b, fxn, rst);
    end
  endtask

  // Reference: integer arithmetic straight from the function table.
  function automatic logic model(input int f, input int x, input int y);
    case (f)
      0: return x == y;
      1: return x != y;
      2: return x >  y;
      3: return x >= y;
      4: return x <  y;
      5: return x <= y;
      6: return (x + y) > MAXV;
      default: return ($countones(x ^ y) % 2) == 1;
    endcase
  endfunction

  // Drive inputs, take one edge, check the registered result; then disturb
  // the inputs mid-cycle and confirm the output did not follow them.
  task automatic apply(input string tag, input logic r, input int x, input int y,
                       input int f, input logic hold_chk);
    logic exp;
    rst = r; a = WIDTH'(x); b = WIDTH'(y); fxn = 3'(f);
    exp = r ? 1'b0 : model(f, x, y);
    @(posedge clk); #1;
    chk(tag, finalresult, exp);
    if (hold_chk) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); fxn = 3'($urandom);
      #3;
      chk({tag, "_hold"}, finalresult, exp);
    end
  endtask

  initial begin
    // 1: reset dominates a > b
    apply("reset", 1'b1, MAXV, 0, 2, 1'b1);
    // 2: a=10, b=47
    apply("lt_10_47", 1'b0, 10, 47, 4, 1'b0);
    apply("gt_10_47", 1'b0, 10, 47, 2, 1'b0);
    apply("ne_10_47", 1'b0, 10, 47, 1, 1'b0);
    // 3: equal operands, sweep compares
    for (int f = 0; f < 6; f++) apply($sformatf("eq_ops_f%0d", f), 1'b0, 21, 21, f, 1'b0);
    apply("par_eq", 1'b0, 21, 21, 7, 1'b0);
    // 4: carry boundaries
    apply("carry_32_32", 1'b0, 32, 32, 6, 1'b0);
    apply("carry_31_32", 1'b0, 31, 32, 6, 1'b0);
    apply("carry_63_63", 1'b0, MAXV, MAXV, 6, 1'b0);
    apply("carry_0_0",   1'b0, 0, 0, 6, 1'b0);
    apply("lt_63_63",    1'b0, MAXV, MAXV, 4, 1'b0);
    // 5: parity
    apply("par_1_0", 1'b0, 1, 0, 7, 1'b0);
    apply("par_3_0", 1'b0, 3, 0, 7, 1'b0);
    // 6: reset mid-run with a held 1
    apply("pre_rst",  1'b0, 10, 47, 4, 1'b0);
    apply("mid_rst",  1'b1, 10, 47, 4, 1'b1);
    apply("post_rst", 1'b0, 10, 47, 4, 1'b0);
    // exhaustive sweep
    for (int f = 0; f < 8; f++)
      for (int x = 0; x <= MAXV; x++)
        for (int y = 0; y <= MAXV; y++)
          apply("sweep", 1'b0, x, y, f, 1'b0);
    // random with sporadic reset and hold checks
    for (int i = 0; i < 2000; i++)
      apply("rand", ($urandom_range(15) == 0), $urandom_range(MAXV),
            $urandom_range(MAXV), $urandom_range(7), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
